// File: rtl/btn_mode_sel_pkg.sv
// Shared mode codes, debounce state type and default debounce length for the mode selector.
// Holds no logic of its own, so it adds no latency and has no backpressure.
package btn_mode_sel_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 50000;

   localparam logic [1:0] MODE_0 = 2'd0;
   localparam logic [1:0] MODE_1 = 2'd1;
   localparam logic [1:0] MODE_2 = 2'd2;
   localparam logic [1:0] MODE_3 = 2'd3;

   typedef enum logic [1:0] {
      DB_IDLE,
      DB_PRESS_WAIT,
      DB_PRESSED,
      DB_RELEASE_WAIT
   } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces one raw button; press_o pulses one cycle on an accepted press.
// Latency: 2 sync flops plus DEBOUNCE_CYCLES+1 stable samples; no backpressure.
module btn_debounce
   import btn_mode_sel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          sync;
   db_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign sync = sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= 2'b00;
         state_q <= DB_IDLE;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[0], btn_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter only runs in the two wait states and is cleared on every transition.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_o = 1'b0;
      case (state_q)
         DB_IDLE: begin
            if (sync) begin
               state_d = DB_PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         DB_PRESS_WAIT: begin
            if (!sync) begin
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DB_PRESSED;
               cnt_d   = '0;
               press_o = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DB_PRESSED: begin
            if (!sync) begin
               state_d = DB_RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         DB_RELEASE_WAIT: begin
            if (sync) begin
               state_d = DB_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = DB_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/btn_mode_sel.sv
// Two debounced buttons step a 2-bit mode up/down modulo 4, gated by lock; mode_chg flags each update.
// Latency: mode moves DEBOUNCE_CYCLES+3 edges after a button is first sampled high; no backpressure.
module btn_mode_sel
   import btn_mode_sel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       lock,
   output logic [1:0] mode,
   output logic       mode_chg
);

   logic       next_press, prev_press;
   logic [1:0] mode_q, mode_d;
   logic       chg_q, chg_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_next),
      .press_o (next_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_prev),
      .press_o (prev_press)
   );

   // Simultaneous presses cancel; presses under lock are dropped, never queued.
   always_comb begin
      mode_d = mode_q;
      chg_d  = 1'b0;
      if (!lock && next_press && !prev_press) begin
         mode_d = mode_q + 2'd1;
         chg_d  = 1'b1;
      end else if (!lock && prev_press && !next_press) begin
         mode_d = mode_q - 2'd1;
         chg_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_0;
         chg_q  <= 1'b0;
      end else begin
         mode_q <= mode_d;
         chg_q  <= chg_d;
      end
   end

   assign mode     = mode_q;
   assign mode_chg = chg_q;

endmodule
